// File: rtl/cpc_rom_reader.sv
// Z80-style bus initiator for CPC expansion ROM boards: optional upper-ROM select
// I/O write to &DF00, then a ROM-enabled memory read in the &C000-&FFFF window.
module cpc_rom_reader #(
    parameter int TDIV = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_rom,
    input  logic [13:0] req_addr,
    input  logic        req_sel_only,
    input  logic        req_force,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_romdis,
    output logic [15:0] A,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic [7:0]  D_in,
    output logic        MREQ_B,
    output logic        IOREQ_B,
    output logic        RD_B,
    output logic        WR_B,
    output logic        ROMEN_B,
    output logic        M1_B,
    output logic        RFSH_B,
    input  logic        READY,
    input  logic        ROMDIS
);

    typedef enum logic [3:0] {
        S_IDLE, S_IOW_T1, S_IOW_T2, S_IOW_TW, S_IOW_T3, S_TI,
        S_MRD_T1, S_MRD_T2, S_MRD_TW, S_MRD_T3, S_RESP
    } state_t;

    localparam int CW = (TDIV > 2) ? $clog2(TDIV) : 1;
    localparam logic [CW-1:0] TLAST = CW'(TDIV - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   tcnt_q, tcnt_d;
    logic            ready_q;
    logic [7:0]      rom_q;
    logic [13:0]     addr_q;
    logic            sel_only_q;
    logic [7:0]      cur_rom_q;
    logic            sel_valid_q;
    logic            rsp_valid_q;
    logic [7:0]      rsp_data_q;
    logic            rsp_romdis_q;
    logic [15:0]     a_q, a_d;
    logic [7:0]      dout_q, dout_d;
    logic            doe_q, doe_d;
    logic            iow_b_q, iow_b_d;
    logic            mrd_b_q, mrd_b_d;

    logic            t_end;
    logic            accept;
    logic            need_iow;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        t_end    = (tcnt_q == TLAST);
        accept   = req_valid && ready_q;
        need_iow = !(sel_valid_q && (cur_rom_q == req_rom) && !req_force && !req_sel_only);
        a_d      = a_q;
        dout_d   = dout_q;

        if (state_q != S_IDLE && state_q != S_RESP)
            tcnt_d = t_end ? '0 : tcnt_q + CW'(1);

        unique case (state_q)
            S_IDLE:   if (accept) state_d = need_iow ? S_IOW_T1 : S_MRD_T1;
            S_IOW_T1: if (t_end) state_d = S_IOW_T2;
            S_IOW_T2,
            S_IOW_TW: if (t_end) state_d = READY ? S_IOW_T3 : S_IOW_TW;
            S_IOW_T3: if (t_end) state_d = sel_only_q ? S_RESP : S_TI;
            S_TI:     if (t_end) state_d = S_MRD_T1;
            S_MRD_T1: if (t_end) state_d = S_MRD_T2;
            S_MRD_T2,
            S_MRD_TW: if (t_end) state_d = READY ? S_MRD_T3 : S_MRD_TW;
            S_MRD_T3: if (t_end) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Address/data are loaded once per phase so they stay stable under the strobes.
        if (accept) begin
            a_d = need_iow ? 16'hDF00 : {2'b11, req_addr};
            if (need_iow) dout_d = req_rom;
        end else if (state_q == S_IOW_T3 && state_d == S_TI) begin
            a_d = {2'b11, addr_q};
        end

        doe_d   = state_d inside {S_IOW_T1, S_IOW_T2, S_IOW_TW, S_IOW_T3};
        iow_b_d = !(state_d inside {S_IOW_T2, S_IOW_TW, S_IOW_T3});
        mrd_b_d = !(state_d inside {S_MRD_T2, S_MRD_TW, S_MRD_T3});
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            tcnt_q       <= '0;
            ready_q      <= 1'b0;
            rom_q        <= '0;
            addr_q       <= '0;
            sel_only_q   <= 1'b0;
            cur_rom_q    <= '0;
            sel_valid_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_romdis_q <= 1'b0;
            a_q          <= '0;
            dout_q       <= '0;
            doe_q        <= 1'b0;
            iow_b_q      <= 1'b1;
            mrd_b_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            ready_q     <= (state_d == S_IDLE);
            rsp_valid_q <= (state_d == S_RESP);
            a_q         <= a_d;
            dout_q      <= dout_d;
            doe_q       <= doe_d;
            iow_b_q     <= iow_b_d;
            mrd_b_q     <= mrd_b_d;

            if (accept) begin
                rom_q      <= req_rom;
                addr_q     <= req_addr;
                sel_only_q <= req_sel_only;
            end

            if (state_q == S_IOW_T3 && t_end) begin
                cur_rom_q   <= rom_q;
                sel_valid_q <= 1'b1;
                if (sel_only_q) begin
                    rsp_data_q   <= '0;
                    rsp_romdis_q <= 1'b0;
                end
            end

            if (state_q == S_MRD_T3 && t_end) begin
                rsp_data_q   <= D_in;
                rsp_romdis_q <= ROMDIS;
            end
        end
    end

    assign req_ready  = ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_romdis = rsp_romdis_q;
    assign A          = a_q;
    assign D_out      = dout_q;
    assign D_oe       = doe_q;
    assign IOREQ_B    = iow_b_q;
    assign WR_B       = iow_b_q;
    assign MREQ_B     = mrd_b_q;
    assign RD_B       = mrd_b_q;
    assign ROMEN_B    = mrd_b_q;
    assign M1_B       = 1'b1;
    assign RFSH_B     = 1'b1;

endmodule

// File: tb/tb_cpc_rom_reader.sv
// Self-checking bench for cpc_rom_reader: ROM-board model on the bus, directed vector
// table, reset/ignore corner sequences and a randomized run against a request-level model.
module tb_cpc_rom_reader;

    localparam int T = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_rom = 8'h00;
    logic [13:0] req_addr = 14'h0000;
    logic        req_sel_only = 1'b0;
    logic        req_force = 1'b0;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_romdis;
    logic [15:0] A;
    logic [7:0]  D_out;
    logic        D_oe;
    logic [7:0]  D_in;
    logic        MREQ_B, IOREQ_B, RD_B, WR_B, ROMEN_B, M1_B, RFSH_B;
    logic        READY = 1'b1;
    logic        ROMDIS;

    int n_cmp = 0;
    int n_err = 0;

    cpc_rom_reader #(.TDIV(T)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_rom(req_rom),
        .req_addr(req_addr), .req_sel_only(req_sel_only), .req_force(req_force),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_romdis(rsp_romdis),
        .A(A), .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
        .MREQ_B(MREQ_B), .IOREQ_B(IOREQ_B), .RD_B(RD_B), .WR_B(WR_B),
        .ROMEN_B(ROMEN_B), .M1_B(M1_B), .RFSH_B(RFSH_B),
        .READY(READY), .ROMDIS(ROMDIS)
    );

    always #5 CLK = ~CLK;

    // ROM contents and ROMDIS behaviour of the modelled boards
    function automatic logic [7:0] rom_byte(input logic [7:0] r, input logic [13:0] a);
        if (r == 8'd7) return 8'h3C;
        if (r == 8'd5 && a == 14'h0000) return 8'hA5;
        return (r * 8'd29) ^ a[7:0] ^ {2'b00, a[13:8]} ^ 8'h5A;
    endfunction

    function automatic logic romdis_of(input logic [7:0] r, input logic [13:0] a);
        if (r == 8'd5) return 1'b1;
        if (r == 8'd7) return 1'b0;
        return ^{r, a};
    endfunction

    // Board latches the upper-ROM number from any I/O write with A13 low
    logic [7:0] board_rom = 8'h00;
    logic       rd_active;
    always @(negedge CLK)
        if (!IOREQ_B && !WR_B && !A[13]) board_rom <= D_out;

    assign rd_active = !MREQ_B && !RD_B && !ROMEN_B && (A[15:14] == 2'b11);
    assign D_in      = rd_active ? rom_byte(board_rom, A[13:0]) : 8'hFF;
    assign ROMDIS    = rd_active ? romdis_of(board_rom, A[13:0]) : 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Request-level reference: select cache of the host side
    bit         m_sv = 1'b0;
    logic [7:0] m_rom = 8'h00;

    task automatic model_req(input logic [7:0] rom, input bit so, input bit fo, output bit need);
        need = !(m_sv && m_rom == rom && !fo && !so);
        if (need) begin
            m_sv  = 1'b1;
            m_rom = rom;
        end
    endtask

    // Issue one request and observe the bus until the response (bounded)
    task automatic run_req(input logic [7:0] rom, input logic [13:0] addr, input bit so,
                           input bit fo, input int iw, input int mw, input bit hold,
                           output int lat, output int iow_lo, output int mrd_lo,
                           output int bad, output logic [7:0] data, output logic rd);
        @(negedge CLK);
        check("req_ready_before_req", 32'(req_ready), 32'd1);
        req_rom = rom; req_addr = addr; req_sel_only = so; req_force = fo; req_valid = 1'b1;
        lat = 0; iow_lo = 0; mrd_lo = 0; bad = 0; data = 8'h00; rd = 1'b0;
        while (lat < 400) begin
            @(negedge CLK);
            lat++;
            if (!(hold && lat < 6)) req_valid = 1'b0;
            req_rom = 8'($urandom); req_addr = 14'($urandom);
            req_sel_only = 1'($urandom); req_force = 1'($urandom);
            if (IOREQ_B != WR_B || MREQ_B != RD_B || MREQ_B != ROMEN_B) bad++;
            if (!IOREQ_B && !MREQ_B) bad++;
            if (!M1_B || !RFSH_B) bad++;
            if (!IOREQ_B) begin
                iow_lo++;
                if (A !== 16'hDF00 || D_out !== rom || D_oe !== 1'b1) bad++;
            end
            if (!MREQ_B) begin
                mrd_lo++;
                if (A !== {2'b11, addr} || D_oe !== 1'b0) bad++;
            end
            if (rsp_valid) begin
                data = rsp_data;
                rd   = rsp_romdis;
                if (!IOREQ_B || !MREQ_B || D_oe) bad++;
                break;
            end
            if (req_ready) bad++;
            READY = !((!IOREQ_B && iow_lo <= iw * T) || (!MREQ_B && mrd_lo <= mw * T));
        end
        READY = 1'b1;
    endtask

    typedef struct {
        logic [7:0]  rom;
        logic [13:0] addr;
        bit          so;
        bit          fo;
        int          iw;
        int          mw;
        int          lat;
        bit          iow;
        logic [7:0]  data;
        logic        romdis;
    } vec_t;

    vec_t vecs[9];

    initial begin : main
        int lat, iow_lo, mrd_lo, bad, n, e_lat;
        logic [7:0] data;
        logic rd;
        bit need, saw;
        logic [7:0]  r_rom;
        logic [13:0] r_addr;
        bit r_so, r_fo;
        int r_iw, r_mw;

        vecs[0] = '{8'd5, 14'h0000, 1'b0, 1'b0, 0, 0, 29, 1'b1, 8'hA5, 1'b1};
        vecs[1] = '{8'd5, 14'h3FFF, 1'b0, 1'b0, 0, 0, 13, 1'b0, rom_byte(8'd5, 14'h3FFF), 1'b1};
        vecs[2] = '{8'd5, 14'h3FFF, 1'b0, 1'b1, 0, 0, 29, 1'b1, rom_byte(8'd5, 14'h3FFF), 1'b1};
        vecs[3] = '{8'd5, 14'h0100, 1'b0, 1'b0, 0, 2, 21, 1'b0, rom_byte(8'd5, 14'h0100), 1'b1};
        vecs[4] = '{8'd5, 14'h0100, 1'b0, 1'b1, 2, 0, 37, 1'b1, rom_byte(8'd5, 14'h0100), 1'b1};
        vecs[5] = '{8'd7, 14'h0000, 1'b1, 1'b0, 0, 0, 13, 1'b1, 8'h00, 1'b0};
        vecs[6] = '{8'd7, 14'h1234, 1'b0, 1'b0, 0, 0, 13, 1'b0, 8'h3C, 1'b0};
        vecs[7] = '{8'd7, 14'h2000, 1'b1, 1'b0, 1, 0, 17, 1'b1, 8'h00, 1'b0};
        vecs[8] = '{8'd5, 14'h0042, 1'b0, 1'b0, 1, 1, 37, 1'b1, rom_byte(8'd5, 14'h0042), 1'b1};

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_romdis", 32'(rsp_romdis), 32'd0);
        check("rst_A", 32'(A), 32'd0);
        check("rst_D_out", 32'(D_out), 32'd0);
        check("rst_D_oe", 32'(D_oe), 32'd0);
        check("rst_strobes", 32'({MREQ_B, IOREQ_B, RD_B, WR_B, ROMEN_B, M1_B, RFSH_B}), 32'h7F);
        RESET = 1'b0;
        @(negedge CLK);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            model_req(vecs[i].rom, vecs[i].so, vecs[i].fo, need);
            run_req(vecs[i].rom, vecs[i].addr, vecs[i].so, vecs[i].fo, vecs[i].iw, vecs[i].mw,
                    1'b0, lat, iow_lo, mrd_lo, bad, data, rd);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_iow_cycles", i), 32'(iow_lo),
                  32'(vecs[i].iow ? (2 + vecs[i].iw) * T : 0));
            check($sformatf("vec%0d_mrd_cycles", i), 32'(mrd_lo),
                  32'(vecs[i].so ? 0 : (2 + vecs[i].mw) * T));
            check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].data));
            check($sformatf("vec%0d_romdis", i), 32'(rd), 32'(vecs[i].romdis));
            check($sformatf("vec%0d_bus_errors", i), 32'(bad), 32'd0);
        end

        // Reset during MRD_T2 of a cached read
        @(negedge CLK);
        req_rom = 8'd5; req_addr = 14'h0042; req_sel_only = 1'b0; req_force = 1'b0;
        req_valid = 1'b1;
        @(negedge CLK);
        req_valid = 1'b0;
        n = 0;
        while (MREQ_B && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("reached_mrd_t2", 32'(MREQ_B), 32'd0);
        RESET = 1'b1;
        @(negedge CLK);
        check("rst_mid_strobes", 32'({MREQ_B, IOREQ_B, RD_B, WR_B, ROMEN_B, M1_B, RFSH_B}), 32'h7F);
        check("rst_mid_D_oe", 32'(D_oe), 32'd0);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_req_ready", 32'(req_ready), 32'd0);
        RESET = 1'b0;
        m_sv = 1'b0;
        saw = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            if (rsp_valid) saw = 1'b1;
        end
        check("rst_mid_no_rsp", 32'(saw), 32'd0);
        model_req(8'd5, 1'b0, 1'b0, need);
        run_req(8'd5, 14'h0042, 1'b0, 1'b0, 0, 0, 1'b0, lat, iow_lo, mrd_lo, bad, data, rd);
        check("post_rst_latency", 32'(lat), 32'd29);
        check("post_rst_iow_cycles", 32'(iow_lo), 32'(2 * T));
        check("post_rst_data", 32'(data), 32'(rom_byte(8'd5, 14'h0042)));

        // Request held while busy must be ignored, not queued
        model_req(8'd5, 1'b0, 1'b0, need);
        run_req(8'd5, 14'h0010, 1'b0, 1'b0, 0, 0, 1'b1, lat, iow_lo, mrd_lo, bad, data, rd);
        check("busy_hold_latency", 32'(lat), 32'd13);
        check("busy_hold_bus_errors", 32'(bad), 32'd0);
        n = 0;
        repeat (20) begin
            @(negedge CLK);
            if (!IOREQ_B || !MREQ_B || D_oe || rsp_valid || !req_ready) n++;
        end
        check("busy_not_queued", 32'(n), 32'd0);

        // Randomized requests against the reference model
        for (int k = 0; k < 40; k++) begin
            r_rom  = 8'($urandom_range(0, 3));
            r_addr = 14'($urandom);
            r_so   = ($urandom_range(0, 7) == 0);
            r_fo   = ($urandom_range(0, 7) == 0);
            r_iw   = int'($urandom_range(0, 2));
            r_mw   = int'($urandom_range(0, 2));
            model_req(r_rom, r_so, r_fo, need);
            e_lat = 1 + (need ? (3 + r_iw) * T : 0)
                      + (r_so ? 0 : ((need ? 1 : 0) + 3 + r_mw) * T);
            run_req(r_rom, r_addr, r_so, r_fo, r_iw, r_mw, 1'b0, lat, iow_lo, mrd_lo, bad, data, rd);
            check($sformatf("rnd%0d_latency", k), 32'(lat), 32'(e_lat));
            check($sformatf("rnd%0d_iow_cycles", k), 32'(iow_lo), 32'(need ? (2 + r_iw) * T : 0));
            check($sformatf("rnd%0d_mrd_cycles", k), 32'(mrd_lo), 32'(r_so ? 0 : (2 + r_mw) * T));
            check($sformatf("rnd%0d_data", k), 32'(data), 32'(r_so ? 8'h00 : rom_byte(r_rom, r_addr)));
            check($sformatf("rnd%0d_romdis", k), 32'(rd), 32'(r_so ? 1'b0 : romdis_of(r_rom, r_addr)));
            check($sformatf("rnd%0d_bus_errors", k), 32'(bad), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
